// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/mem memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_I_ADDR,
        ARB_I_WAIT,
        ARB_D_ADDR,
        ARB_D_WAIT
    } arbState_t;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam logic [3:0]  SEL_FULL       = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported memory bus between fetch and mem stages;
// data has priority, fetch is forced through after STARVE_MAX data grants.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic              inst_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_sel,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arbState_t  state;
    arbState_t  stateNext;
    logic [3:0] starveCnt;
    logic       discard;

    logic instPend;
    logic dataPend;
    logic starved;
    logic grantI;
    logic grantD;
    logic instDone;
    logic dataDone;
    logic dropInst;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= stateNext;
    end

    // Next-state, grant and completion decode
    always_comb begin
        // A request whose ok is already high is the one just served
        instPend  = inst_req & ~inst_ok;
        dataPend  = data_req & ~data_ok;
        starved   = (starveCnt == STARVE_LIM);
        grantI    = 1'b0;
        grantD    = 1'b0;
        instDone  = 1'b0;
        dataDone  = 1'b0;
        stateNext = state;
        case (state)
            ARB_IDLE: begin
                if (instPend && starved) begin
                    grantI    = 1'b1;
                    stateNext = ARB_I_ADDR;
                end else if (dataPend) begin
                    grantD    = 1'b1;
                    stateNext = ARB_D_ADDR;
                end else if (instPend) begin
                    grantI    = 1'b1;
                    stateNext = ARB_I_ADDR;
                end
            end
            ARB_I_ADDR: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        instDone  = 1'b1;
                        stateNext = ARB_IDLE;
                    end else begin
                        stateNext = ARB_I_WAIT;
                    end
                end
            end
            ARB_I_WAIT: begin
                if (bus_data_ok) begin
                    instDone  = 1'b1;
                    stateNext = ARB_IDLE;
                end
            end
            ARB_D_ADDR: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        dataDone  = 1'b1;
                        stateNext = ARB_IDLE;
                    end else begin
                        stateNext = ARB_D_WAIT;
                    end
                end
            end
            ARB_D_WAIT: begin
                if (bus_data_ok) begin
                    dataDone  = 1'b1;
                    stateNext = ARB_IDLE;
                end
            end
            default: stateNext = ARB_IDLE;
        endcase
        // A cancel arriving in the completion cycle itself also drops the result
        dropInst = discard | inst_cancel;
    end

    // Bus request/field registers, latched at grant and held through the transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (grantI) begin
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_sel   <= SEL_FULL;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
        end else if (grantD) begin
            bus_req   <= 1'b1;
            bus_wr    <= data_wr;
            bus_sel   <= data_sel;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
        end else if ((state == ARB_I_ADDR || state == ARB_D_ADDR) && bus_addr_ok) begin
            bus_req   <= 1'b0;
        end
    end

    // Port completion pulses and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_ok    <= 1'b0;
            data_ok    <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            inst_ok <= instDone & ~dropInst;
            data_ok <= dataDone;
            if (instDone && !dropInst) inst_rdata <= bus_rdata;
            if (dataDone)              data_rdata <= bus_rdata;
        end
    end

    // Starvation counter and fetch-discard flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
            discard   <= 1'b0;
        end else begin
            if (grantI)
                starveCnt <= '0;
            else if (grantD && instPend && !starved)
                starveCnt <= starveCnt + 4'd1;

            if (instDone)
                discard <= 1'b0;
            else if (inst_cancel && (state == ARB_I_ADDR || state == ARB_I_WAIT))
                discard <= 1'b1;
        end
    end

endmodule
